// File: rtl/periph_bus_arbiter.sv
// Round-robin owner of the shared peripheral bus for the CPU, graphics and audio requesters.
// Each grant runs a fixed ADDR / WAIT / DONE sequence with Addr[15:12] chip-select decode.
module periph_bus_arbiter #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [2:0]  we,
    input  logic [47:0] addr_in,
    input  logic [47:0] wdata_in,
    output logic [2:0]  gnt,
    output logic [2:0]  ack,
    output logic [15:0] rdata,
    output logic [15:0] Addr,
    output logic [15:0] WriteData,
    output logic        Read,
    output logic        Write,
    input  logic [15:0] ReadData,
    output logic        CS_RAM,
    output logic        CS_Graphics,
    output logic        CS_Audio,
    output logic        CS_Spart,
    output logic        CS_PS2
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WAIT,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic ram;
        logic graphics;
        logic audio;
        logic spart;
        logic ps2;
    } cs_t;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);
    localparam logic       HAS_WAIT  = (WAIT_CYCLES != 0);

    function automatic cs_t cs_decode(input logic [3:0] region);
        cs_t cs;
        cs = '0;
        case (region)
            4'hC:    cs.graphics = 1'b1;
            4'hD:    cs.audio    = 1'b1;
            4'hE:    cs.spart    = 1'b1;
            4'hF:    cs.ps2      = 1'b1;
            default: cs.ram      = 1'b1;
        endcase
        return cs;
    endfunction

    state_t      state_q;
    logic [1:0]  last_q;
    logic [2:0]  gnt_q;
    logic [2:0]  ack_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic [15:0] rdata_q;
    logic        read_q;
    logic        write_q;
    cs_t         cs_q;
    logic [3:0]  cnt_q;

    logic [1:0]  win_d;
    logic [15:0] win_addr;
    logic [15:0] win_wdata;
    logic        win_we;
    logic        bus_last;

    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        win_d = 2'd0;
        case (last_q)
            2'd0:    win_d = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
            2'd1:    win_d = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
            default: win_d = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
        endcase
    end

    always_comb begin
        win_addr  = addr_in[15:0];
        win_wdata = wdata_in[15:0];
        win_we    = we[0];
        case (win_d)
            2'd1: begin
                win_addr  = addr_in[31:16];
                win_wdata = wdata_in[31:16];
                win_we    = we[1];
            end
            2'd2: begin
                win_addr  = addr_in[47:32];
                win_wdata = wdata_in[47:32];
                win_we    = we[2];
            end
            default: ;
        endcase
    end

    // Final bus cycle: ReadData is sampled on the edge that ends it.
    assign bus_last = ((state_q == ST_ADDR) && !HAS_WAIT) ||
                      ((state_q == ST_WAIT) && (cnt_q == 4'd1));

    // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            last_q  <= 2'd2;
            gnt_q   <= '0;
            ack_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            cs_q    <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|req) begin
                        gnt_q   <= 3'b001 << win_d;
                        last_q  <= win_d;
                        addr_q  <= win_addr;
                        wdata_q <= win_wdata;
                        read_q  <= ~win_we;
                        write_q <= win_we;
                        cs_q    <= cs_decode(win_addr[15:12]);
                        state_q <= ST_ADDR;
                    end
                end
                ST_ADDR, ST_WAIT: begin
                    write_q <= 1'b0;
                    if (bus_last) begin
                        if (read_q) begin
                            rdata_q <= ReadData;
                        end
                        read_q  <= 1'b0;
                        cs_q    <= '0;
                        ack_q   <= gnt_q;
                        state_q <= ST_DONE;
                    end else if (state_q == ST_ADDR) begin
                        cnt_q   <= WAIT_LOAD;
                        state_q <= ST_WAIT;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_DONE: begin
                    ack_q   <= '0;
                    gnt_q   <= '0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign gnt         = gnt_q;
    assign ack         = ack_q;
    assign rdata       = rdata_q;
    assign Addr        = addr_q;
    assign WriteData   = wdata_q;
    assign Read        = read_q;
    assign Write       = write_q;
    assign CS_RAM      = cs_q.ram;
    assign CS_Graphics = cs_q.graphics;
    assign CS_Audio    = cs_q.audio;
    assign CS_Spart    = cs_q.spart;
    assign CS_PS2      = cs_q.ps2;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Scoreboard bench for periph_bus_arbiter: a transaction-level model predicts each grant,
// and a negedge monitor checks the bus sequence of every grant it observes.
module tb_periph_bus_arbiter;

    localparam int W = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req = '0;
    logic [2:0]  we = '0;
    logic [47:0] addr_in = '0;
    logic [47:0] wdata_in = '0;
    logic [2:0]  gnt;
    logic [2:0]  ack;
    logic [15:0] rdata;
    logic [15:0] Addr;
    logic [15:0] WriteData;
    logic        Read;
    logic        Write;
    logic [15:0] ReadData;
    logic        CS_RAM, CS_Graphics, CS_Audio, CS_Spart, CS_PS2;
    logic [4:0]  cs_vec;

    assign cs_vec = {CS_RAM, CS_Graphics, CS_Audio, CS_Spart, CS_PS2};

    always #5 clk = ~clk;

    periph_bus_arbiter #(.WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr_in(addr_in), .wdata_in(wdata_in),
        .gnt(gnt), .ack(ack), .rdata(rdata), .Addr(Addr), .WriteData(WriteData),
        .Read(Read), .Write(Write), .ReadData(ReadData),
        .CS_RAM(CS_RAM), .CS_Graphics(CS_Graphics), .CS_Audio(CS_Audio),
        .CS_Spart(CS_Spart), .CS_PS2(CS_PS2)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] slave_data(input logic [15:0] a);
        return a ^ 16'hBEAD;
    endfunction

    function automatic logic [4:0] exp_cs(input logic [15:0] a);
        if (a[15:12] <= 4'hB)       return 5'b10000;
        else if (a[15:12] == 4'hC)  return 5'b01000;
        else if (a[15:12] == 4'hD)  return 5'b00100;
        else if (a[15:12] == 4'hE)  return 5'b00010;
        else                        return 5'b00001;
    endfunction

    // Slave: valid data only during the last bus cycle of a read, garbage otherwise.
    int rd_cnt = 0;
    always @(negedge clk or negedge rst) begin
        if (!rst)      rd_cnt = 0;
        else if (Read) rd_cnt++;
        else           rd_cnt = 0;
    end
    assign ReadData = (Read && rd_cnt == W + 1) ? slave_data(Addr) : 16'hDEAD;

    typedef struct {
        int          port;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
    } txn_t;

    txn_t exp_q[$];

    // Reference model: bus busy for W+2 edges after each grant, round-robin search from last+1.
    int          m_last = 2;
    int          m_busy = 0;
    int          m_win;
    int          m_cand;
    logic [15:0] m_rdata = '0;
    txn_t        m_t;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_last  = 2;
            m_busy  = 0;
            m_rdata = '0;
            exp_q.delete();
        end else if (m_busy > 0) begin
            m_busy--;
        end else if (req != 3'b000) begin
            m_win = -1;
            for (int o = 1; o <= 3; o++) begin
                m_cand = (m_last + o) % 3;
                if (m_win < 0 && req[m_cand]) m_win = m_cand;
            end
            m_t.port  = m_win;
            m_t.we    = we[m_win];
            m_t.addr  = addr_in[16*m_win +: 16];
            m_t.wdata = wdata_in[16*m_win +: 16];
            m_t.rdata = m_t.we ? m_rdata : slave_data(m_t.addr);
            m_rdata   = m_t.rdata;
            exp_q.push_back(m_t);
            m_last = m_win;
            m_busy = W + 2;
        end
    end

    txn_t        cur;
    bit          active = 1'b0;
    int          phase = 0;
    logic [2:0]  cur_g = '0;
    logic [15:0] rdata_exp = '0;
    int          write_cycles = 0;
    int          grant_log[$];
    logic [4:0]  last_cs = '0;

    always @(negedge clk) begin
        if (!rst) begin
            check("reset_outputs", {gnt, ack, Read, Write, cs_vec, rdata, Addr, WriteData}, 64'h0);
            active    = 1'b0;
            phase     = 0;
            rdata_exp = '0;
        end else begin
            if (Write) write_cycles++;
            if (!active) begin
                if (gnt != 3'b000) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_grant", {61'h0, gnt}, 64'h0);
                    end else begin
                        cur     = exp_q.pop_front();
                        cur_g   = 3'(1 << cur.port);
                        active  = 1'b1;
                        phase   = 1;
                        last_cs = cs_vec;
                        grant_log.push_back(cur.port);
                        check("addr_gnt", gnt, cur_g);
                        check("addr_bus", {Addr, cs_vec, Read, Write, ack},
                              {cur.addr, exp_cs(cur.addr), ~cur.we, cur.we, 3'b000});
                        if (cur.we) check("addr_wdata", WriteData, cur.wdata);
                    end
                end else begin
                    check("idle_quiet", {ack, Read, Write, cs_vec}, 64'h0);
                    check("rdata_hold", rdata, rdata_exp);
                end
            end else begin
                phase++;
                if (phase <= W + 1) begin
                    check("wait_bus", {gnt, ack, Addr, cs_vec, Read, Write},
                          {cur_g, 3'b000, cur.addr, exp_cs(cur.addr), ~cur.we, 1'b0});
                end else if (phase == W + 2) begin
                    check("done_bus", {gnt, ack, Addr, cs_vec, Read, Write},
                          {cur_g, cur_g, cur.addr, 5'b00000, 1'b0, 1'b0});
                    check("done_rdata", rdata, cur.rdata);
                    rdata_exp = cur.rdata;
                end else begin
                    check("idle_after_done", {gnt, ack}, 64'h0);
                    active = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || active) && n < 100) begin
            tick();
            n++;
        end
        check("drain_timeout", n >= 100, 0);
    endtask

    task automatic wait_gnt(input logic [2:0] target, input string name);
        int n = 0;
        while (gnt !== target && n < 50) begin
            tick();
            n++;
        end
        check(name, gnt, target);
    endtask

    // Requests for one cycle only, then scrambles the inputs to prove they were latched at grant.
    task automatic issue(input int p, input logic w_en, input logic [15:0] a, input logic [15:0] d);
        we[p]              = w_en;
        addr_in[16*p +: 16]  = a;
        wdata_in[16*p +: 16] = d;
        req                = 3'(1 << p);
        tick();
        req      = '0;
        we       = ~we;
        addr_in  = ~addr_in;
        wdata_in = ~wdata_in;
        drain();
    endtask

    int          rr_exp[6]     = '{0, 1, 2, 0, 1, 2};
    logic [15:0] sweep_addr[6] = '{16'h0000, 16'hB000, 16'hC000, 16'hD000, 16'hE000, 16'hF000};
    logic [4:0]  sweep_cs[6]   = '{5'b10000, 5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001};
    int          wc0;
    int          n;

    initial begin
        #1 rst = 1'b0;
        req = 3'b111;
        repeat (3) tick();
        check("reset_state", {gnt, ack, Read, Write, cs_vec}, 64'h0);
        rst = 1'b1;
        tick();
        check("first_grant", gnt, 3'b001);
        req = '0;
        drain();

        issue(0, 1'b0, 16'h0042, 16'h0000);
        check("single_read_rdata", rdata, 16'hBEEF);

        wc0 = write_cycles;
        issue(2, 1'b1, 16'hE001, 16'h1234);
        check("write_once", write_cycles - wc0, 1);
        check("write_keeps_rdata", rdata, 16'hBEEF);

        grant_log.delete();
        req = 3'b111;
        n = 0;
        while (grant_log.size() < 6 && n < 200) begin
            tick();
            n++;
        end
        req = '0;
        drain();
        check("rr_count", grant_log.size() >= 6, 1);
        for (int i = 0; i < 6 && i < grant_log.size(); i++) check("rr_order", grant_log[i], rr_exp[i]);

        for (int i = 0; i < 6; i++) begin
            issue(1, 1'b0, sweep_addr[i], 16'h0000);
            check("sweep_cs", last_cs, sweep_cs[i]);
        end

        for (int c = 0; c < 400; c++) begin
            req      = 3'($urandom_range(0, 7));
            we       = 3'($urandom());
            addr_in  = {16'($urandom()), 16'($urandom()), 16'($urandom())};
            wdata_in = {16'($urandom()), 16'($urandom()), 16'($urandom())};
            tick();
        end
        req = '0;
        drain();

        // Abort a read in its WAIT cycle; requester 1 also waiting exposes the pointer reset.
        we      = 3'b000;
        addr_in = {16'h0000, 16'h2000, 16'h3000};
        req     = 3'b011;
        wait_gnt(3'b001, "abort_first_grant");
        @(posedge clk);
        #3;
        check("abort_in_wait", {gnt, Read}, {3'b001, 1'b1});
        rst = 1'b0;
        #1;
        check("abort_clear", {gnt, ack, Read, Write, cs_vec, Addr, WriteData, rdata}, 64'h0);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        check("abort_regrant", gnt, 3'b001);
        req = '0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/periph_bus_arbiter.md
Name: periph_bus_arbiter

Overview:
- Shares the single peripheral bus (Addr, WriteData, Read, Write, chip selects) between three requesters.
  - Port 0: CPU load/store path.
  - Port 1: graphics fetch.
  - Port 2: audio sample fetch.
- Round-robin arbitration; each granted transaction is sequenced through a fixed address/wait/complete cycle.
- Decodes Addr[15:12] into the peripheral chip selects and returns captured read data with a one-cycle ack.
- Sits between the requesters and External_Mem/peripherals, replacing direct CPU ownership of the bus.

Parameters:
- WAIT_CYCLES, 1, extra bus cycles after the address cycle before read data is sampled (0..15 legal).

Ports:
- clk  in  1  system clock (cpuclk domain).
- rst  in  1  asynchronous, active-low reset.
- req  in  3  per-requester request, level; bit i = requester i.
- we  in  3  per-requester write enable, valid while req high.
- addr_in  in  48  requester addresses, [16i+15:16i] = requester i.
- wdata_in  in  48  requester write data, same packing.
- gnt  out  3  one-hot grant, high from ADDR through DONE.
- ack  out  3  one-hot, one-cycle completion pulse.
- rdata  out  16  captured read data, valid in the ack cycle; held until the next capture.
- Addr  out  16  bus address.
- WriteData  out  16  bus write data.
- Read  out  1  bus read strobe.
- Write  out  1  bus write strobe.
- ReadData  in  16  bus read data from the selected slave.
- CS_RAM, CS_Graphics, CS_Audio, CS_Spart, CS_PS2  out  1 each  active-high chip selects.

Behaviour:
- Reset (rst low, async): state IDLE.
  - gnt=0, ack=0, rdata=0, Addr=0, WriteData=0, Read=0, Write=0, all CS=0.
  - Round-robin pointer last=2, so requester 0 wins first.
- States: IDLE, ADDR, WAIT, DONE. All outputs are registered.
- IDLE:
  - If any req bit is set, select the first set bit searching from (last+1) mod 3 upward with wrap.
  - Latch that requester's addr/wdata/we; set gnt one-hot and last=winner; go to ADDR.
  - If no req bit is set, stay in IDLE.
- ADDR (1 cycle):
  - Addr/WriteData driven from the latched values; decoded CS asserted.
  - Read=~we_latched; Write=we_latched. Write is high in this cycle only, so each write occurs exactly once.
  - If WAIT_CYCLES=0, go to DONE; else load the wait counter and go to WAIT.
- WAIT (WAIT_CYCLES cycles):
  - Addr, CS and Read held; Write=0.
  - Counter decrements; at 1, go to DONE.
- Read-data capture: on the edge leaving the last bus cycle (ADDR or WAIT), ReadData is registered into rdata, for reads only. Writes leave rdata unchanged.
- DONE (1 cycle):
  - Read=0, Write=0, CS=0; Addr holds.
  - ack[winner]=1; gnt still high.
  - Next state is IDLE; gnt clears on entry to IDLE.
- Transaction latency: req sampled in IDLE at edge k; ack high in cycle k+2+WAIT_CYCLES. Minimum spacing between grants is 3+WAIT_CYCLES cycles.
- CS decode of Addr[15:12]:
  - 0x0-0xB: CS_RAM.
  - 0xC: CS_Graphics.
  - 0xD: CS_Audio.
  - 0xE: CS_Spart.
  - 0xF: CS_PS2.
  - Exactly one CS is high in ADDR/WAIT; all are low otherwise.
- Requester rules:
  - addr/wdata/we are sampled only at grant; later changes are ignored.
  - Dropping req mid-transaction does not abort: the bus cycle completes and ack still pulses.
  - A requester holding req after ack re-enters arbitration in the following IDLE cycle at lowest priority.
- Simultaneous requests: exactly one winner per IDLE cycle; non-winners wait, with no starvation.
  - Worst case wait is 2 transactions.
- Reset mid-transaction: all outputs clear immediately (async), no ack is issued, and the pointer returns to 2.

Test Plan:
- Reset: hold rst=0 with req=3'b111 → gnt=0, ack=0, all CS=0, Read=Write=0. Release → first gnt=3'b001.
- Single read, WAIT_CYCLES=1:
  - Stimulus: req[0]=1, we=0, addr=0x0042, ReadData=0xBEEF.
  - Required: ADDR at k+1 with CS_RAM=1, Read=1; WAIT at k+2; ack[0] at k+3; rdata=0xBEEF; Write never high.
- Write to 0xE001 from requester 2, wdata=0x1234:
  - Write=1 for exactly one cycle with CS_Spart=1 and WriteData=0x1234.
  - ack[2] pulses; rdata unchanged.
- Round-robin: req=3'b111 held continuously → grant order 0,1,2,0,1,2. Each ack is one cycle; gnt is never multi-hot.
- Decode sweep: reads at Addr 0x0000, 0xB000, 0xC000, 0xD000, 0xE000, 0xF000 → RAM, RAM, Graphics, Audio, Spart, PS2 respectively; exactly one CS each.
- Abort: assert rst=0 during WAIT of a read → outputs clear the same cycle; no ack; after release the requester still holding req is re-granted from IDLE.
